// File: rtl/midi_pkg.sv
// Shared types and helpers for the MIDI IN receive path.
package midi_pkg;

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} midi_rx_state_t;

  localparam int unsigned MIDI_BAUD = 31250;

  // Rounded clk/(baud*ovs), never below 2 so the prescaler is at least one bit wide.
  function automatic int unsigned calc_div(input int unsigned clk_hz,
                                           input int unsigned baud,
                                           input int unsigned ovs);
    int unsigned den;
    int unsigned div;
    den = baud * ovs;
    div = (clk_hz + den / 2) / den;
    if (div < 2) div = 2;
    return div;
  endfunction

endpackage

// File: rtl/midi_rx_fifo.sv
// First-word-fall-through receive FIFO; dout is registered from the head entry.
module midi_rx_fifo #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned WIDTH = 8
) (
  input  logic                     clk_sys,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         din,
  input  logic                     pop,
  output logic [WIDTH-1:0]         dout,
  output logic                     valid,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     drop
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr, rd_ptr_n;
  logic [CW-1:0]    count_n;
  logic [WIDTH-1:0] head_n;
  logic             full, do_push, do_pop;

  assign valid = (count != '0);

  always_comb begin
    full     = (count == CW'(DEPTH));
    do_pop   = pop && (count != '0);
    do_push  = push && (!full || do_pop);
    drop     = push && full && !do_pop;
    rd_ptr_n = do_pop ? rd_ptr + AW'(1) : rd_ptr;
    count_n  = count;
    if (do_push && !do_pop)
      count_n = count + CW'(1);
    else if (!do_push && do_pop)
      count_n = count - CW'(1);
    // A byte written this cycle becomes the head only when it lands on the next read slot.
    head_n = (do_push && (wr_ptr == rd_ptr_n)) ? din : mem[rd_ptr_n];
  end

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      dout   <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      rd_ptr <= rd_ptr_n;
      count  <= count_n;
      if (count_n != '0) dout <= head_n;
    end
  end

  always_ff @(posedge clk_sys) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/midi_uart_rx.sv
// MIDI IN receiver: 8N1 serial with 16x oversampling and 3-sample majority vote,
// bytes buffered in a FWFT FIFO read through valid/ready.
module midi_uart_rx
  import midi_pkg::*;
#(
  parameter int unsigned CLK_HZ     = 40_000_000,
  parameter int unsigned BAUD       = MIDI_BAUD,
  parameter int unsigned OVS        = 16,
  parameter int unsigned FIFO_DEPTH = 16
) (
  input  logic                          clk_sys,
  input  logic                          reset,
  input  logic                          midi_rx,
  input  logic                          clr_err,
  output logic [7:0]                    rx_data,
  output logic                          rx_valid,
  input  logic                          rx_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          overrun,
  output logic [7:0]                    frame_err_cnt,
  output logic                          rx_active
);

  localparam int unsigned DIV = calc_div(CLK_HZ, BAUD, OVS);
  localparam int unsigned PW  = $clog2(DIV);
  localparam int unsigned TW  = $clog2(OVS);
  localparam int unsigned MID = OVS / 2 - 1;

  midi_rx_state_t state;
  logic [1:0]     sync_ff;
  logic           line, line_d;
  logic           s2, s1;
  logic [PW-1:0]  presc;
  logic [TW-1:0]  tick_cnt, tick_num;
  logic [2:0]     bit_idx;
  logic [7:0]     shreg;
  logic           tick, maj, decide, stop_dec, push, frame_err, drop;

  assign line = sync_ff[1];

  // tick_num is the ordinal of the current tick within the bit; the third sample is the live line.
  always_comb begin
    tick      = (state != IDLE) && (presc == PW'(DIV - 1));
    tick_num  = tick_cnt + TW'(1);
    maj       = (s2 & s1) | (s2 & line) | (s1 & line);
    decide    = tick && (tick_num == TW'(MID + 1));
    stop_dec  = (state == STOP) && decide;
    push      = stop_dec && maj;
    frame_err = stop_dec && !maj;
  end

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      sync_ff <= '1;
      line_d  <= 1'b1;
    end else begin
      sync_ff <= {sync_ff[0], midi_rx};
      line_d  <= line;
    end
  end

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      presc         <= '0;
      tick_cnt      <= '0;
      bit_idx       <= '0;
      shreg         <= '0;
      s2            <= 1'b1;
      s1            <= 1'b1;
      rx_active     <= 1'b0;
      frame_err_cnt <= '0;
      overrun       <= 1'b0;
    end else begin
      if (state == IDLE || tick) presc <= '0;
      else                       presc <= presc + PW'(1);

      if (tick) begin
        s2 <= s1;
        s1 <= line;
      end

      case (state)
        IDLE: begin
          if (line_d && !line) begin
            state     <= START;
            tick_cnt  <= '0;
            rx_active <= 1'b1;
          end
        end
        START: begin
          if (tick) tick_cnt <= tick_num;
          if (decide) begin
            if (maj) begin
              state     <= IDLE;
              rx_active <= 1'b0;
            end else begin
              state   <= DATA;
              bit_idx <= '0;
            end
          end
        end
        DATA: begin
          if (tick) tick_cnt <= tick_num;
          if (decide) begin
            shreg   <= {maj, shreg[7:1]};
            bit_idx <= bit_idx + 3'd1;
            if (bit_idx == 3'd7) state <= STOP;
          end
        end
        STOP: begin
          if (tick) tick_cnt <= tick_num;
          if (decide) begin
            if (maj) begin
              state     <= IDLE;
              rx_active <= 1'b0;
            end else begin
              state    <= BREAK;
              tick_cnt <= '0;
            end
          end
        end
        BREAK: begin
          // tick_cnt counts consecutive high ticks; any low tick restarts the bit-time wait.
          if (tick) begin
            if (!line) begin
              tick_cnt <= '0;
            end else if (tick_cnt == TW'(OVS - 1)) begin
              state     <= IDLE;
              rx_active <= 1'b0;
            end else begin
              tick_cnt <= tick_num;
            end
          end
        end
        default: begin
          state     <= IDLE;
          rx_active <= 1'b0;
        end
      endcase

      if (clr_err)
        frame_err_cnt <= {7'd0, frame_err};
      else if (frame_err && frame_err_cnt != 8'hFF)
        frame_err_cnt <= frame_err_cnt + 8'd1;

      if (drop)         overrun <= 1'b1;
      else if (clr_err) overrun <= 1'b0;
    end
  end

  midi_rx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clk_sys (clk_sys),
    .reset   (reset),
    .push    (push),
    .din     (shreg),
    .pop     (rx_ready),
    .dout    (rx_data),
    .valid   (rx_valid),
    .count   (fifo_count),
    .drop    (drop)
  );

endmodule
